// File: rtl/dmme_pkg.sv
// Shared types and constants for the dmme operand feeder and engine.
package dmme_pkg;

    localparam int unsigned DW = 64;

    localparam logic MODE_DENDEN = 1'b0;
    localparam logic MODE_SPADEN = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFeed,
        StDrain,
        StWait,
        StResult
    } state_e;

endpackage

// File: rtl/dmme_skew_reg.sv
// Lane-2 one-beat delay: holds a2/b2 of the previous accepted beat.
module dmme_skew_reg #(
    parameter int unsigned DW = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o
);

    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q <= '0;
            b_q <= '0;
        end else if (clr_i) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/dmme_feeder.sv
// Operand sequencer for dmme_nonmem: skews lane 2 by one beat, drains, and
// returns the engine results over a valid/ready port.
module dmme_feeder #(
    parameter int unsigned DW    = dmme_pkg::DW,
    parameter int unsigned KW    = 4,
    parameter int unsigned DRAIN = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic          cfg_mode_i,
    input  logic [3:0]    cfg_mask11_1_i,
    input  logic [3:0]    cfg_mask21_1_i,
    input  logic [3:0]    cfg_mask11_2_i,
    input  logic [3:0]    cfg_mask21_2_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_a1_i,
    input  logic [DW-1:0] s_b1_i,
    input  logic [DW-1:0] s_a2_i,
    input  logic [DW-1:0] s_b2_i,
    input  logic          s_last_i,
    output logic          eng_rst_o,
    output logic          eng_en_o,
    output logic          eng_mode_o,
    output logic [3:0]    eng_mask11_1_o,
    output logic [3:0]    eng_mask21_1_o,
    output logic [3:0]    eng_mask11_2_o,
    output logic [3:0]    eng_mask21_2_o,
    output logic [DW-1:0] eng_ain1_o,
    output logic [DW-1:0] eng_bin1_o,
    output logic [DW-1:0] eng_ain2_o,
    output logic [DW-1:0] eng_bin2_o,
    input  logic          eng_done_i,
    input  logic [31:0]   eng_c12_1_i,
    input  logic [31:0]   eng_c22_1_i,
    input  logic [31:0]   eng_c12_2_i,
    input  logic [31:0]   eng_c22_2_i,
    output logic          r_valid_o,
    input  logic          r_ready_i,
    output logic [31:0]   r_c12_1_o,
    output logic [31:0]   r_c22_1_o,
    output logic [31:0]   r_c12_2_o,
    output logic [31:0]   r_c22_2_o
);

    import dmme_pkg::*;

    localparam int unsigned DCW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

    state_e          state_q, state_d;
    logic            cfg_ready_q, eng_rst_q, en_q, en_d, r_valid_q;
    logic            mode_q;
    logic [15:0]     mask_q;
    logic [KW-1:0]   beat_cnt_q;
    logic [DCW-1:0]  drain_cnt_q;
    logic [DW-1:0]   ain1_q, bin1_q, ain2_q, bin2_q;
    logic [DW-1:0]   ain1_d, bin1_d, ain2_d, bin2_d;
    logic [DW-1:0]   skew_a, skew_b;
    logic            skew_load, skew_clr;
    logic [31:0]     r_c12_1_q, r_c22_1_q, r_c12_2_q, r_c22_2_q;
    logic            cfg_accept, beat, last_beat, done_ok, drive;

    assign cfg_accept = (state_q == StIdle) && cfg_valid_i && cfg_ready_q;
    assign beat       = (state_q == StFeed) && s_valid_i;
    // A full counter forces the beat to be the job's last one.
    assign last_beat  = beat && (s_last_i || (beat_cnt_q == '1));
    assign done_ok    = eng_done_i &&
                        (((state_q == StDrain) && (drain_cnt_q != '0)) || (state_q == StWait));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (cfg_accept) state_d = StStart;
            StStart:  state_d = StFeed;
            StFeed:   if (last_beat) state_d = StDrain;
            StDrain: begin
                if (done_ok) begin
                    state_d = StResult;
                end else if (drain_cnt_q == DCW'(DRAIN)) begin
                    state_d = StWait;
                end
            end
            StWait:   if (done_ok) state_d = StResult;
            StResult: if (r_ready_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ain1_d    = ain1_q;
        bin1_d    = bin1_q;
        ain2_d    = ain2_q;
        bin2_d    = bin2_q;
        en_d      = 1'b0;
        skew_load = 1'b0;
        skew_clr  = 1'b0;
        if (state_q == StFeed) begin
            if (beat) begin
                ain1_d    = s_a1_i;
                bin1_d    = s_b1_i;
                ain2_d    = skew_a;
                bin2_d    = skew_b;
                skew_load = 1'b1;
                en_d      = 1'b1;
            end
        end else if ((state_q == StDrain) && (state_d != StResult)) begin
            // Skew drains into lane 2 once, then reads back as zero.
            ain1_d   = '0;
            bin1_d   = '0;
            ain2_d   = skew_a;
            bin2_d   = skew_b;
            skew_clr = 1'b1;
            en_d     = 1'b1;
        end else begin
            ain1_d   = '0;
            bin1_d   = '0;
            ain2_d   = '0;
            bin2_d   = '0;
            skew_clr = 1'b1;
            en_d     = (state_q == StWait) && (state_d == StWait);
        end
    end

    dmme_skew_reg #(
        .DW (DW)
    ) u_skew (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (skew_load),
        .clr_i  (skew_clr),
        .a_i    (s_a2_i),
        .b_i    (s_b2_i),
        .a_o    (skew_a),
        .b_o    (skew_b)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cfg_ready_q <= 1'b0;
            eng_rst_q   <= 1'b0;
            en_q        <= 1'b0;
            r_valid_q   <= 1'b0;
            mode_q      <= MODE_DENDEN;
            mask_q      <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            ain1_q      <= '0;
            bin1_q      <= '0;
            ain2_q      <= '0;
            bin2_q      <= '0;
            r_c12_1_q   <= '0;
            r_c22_1_q   <= '0;
            r_c12_2_q   <= '0;
            r_c22_2_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= (state_d == StIdle);
            eng_rst_q   <= (state_d != StStart);
            en_q        <= en_d;
            r_valid_q   <= (state_d == StResult);
            ain1_q      <= ain1_d;
            bin1_q      <= bin1_d;
            ain2_q      <= ain2_d;
            bin2_q      <= bin2_d;
            drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
            if (cfg_accept) begin
                mode_q <= cfg_mode_i;
                mask_q <= {cfg_mask11_1_i, cfg_mask21_1_i, cfg_mask11_2_i, cfg_mask21_2_i};
            end
            if (state_q == StStart) begin
                beat_cnt_q <= '0;
            end else if (beat && (beat_cnt_q != '1)) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (done_ok) begin
                r_c12_1_q <= eng_c12_1_i;
                r_c22_1_q <= eng_c22_1_i;
                r_c12_2_q <= eng_c12_2_i;
                r_c22_2_q <= eng_c22_2_i;
            end
        end
    end

    assign drive       = (state_q != StIdle);
    assign cfg_ready_o = cfg_ready_q;
    assign s_ready_o   = (state_q == StFeed);
    assign eng_rst_o   = eng_rst_q;
    assign eng_en_o    = en_q;
    assign eng_mode_o  = drive & mode_q;
    assign {eng_mask11_1_o, eng_mask21_1_o, eng_mask11_2_o, eng_mask21_2_o} =
        drive ? mask_q : 16'h0;
    assign eng_ain1_o  = ain1_q;
    assign eng_bin1_o  = bin1_q;
    assign eng_ain2_o  = ain2_q;
    assign eng_bin2_o  = bin2_q;
    assign r_valid_o   = r_valid_q;
    assign r_c12_1_o   = r_c12_1_q;
    assign r_c22_1_o   = r_c22_1_q;
    assign r_c12_2_o   = r_c12_2_q;
    assign r_c22_2_o   = r_c22_2_q;

endmodule

// File: tb/tb_dmme_feeder.sv
// Cycle-scripted bench: per-job expected waveforms are derived from the beat
// schedule, done cycle and result handshake cycle.
module tb_dmme_feeder;

    localparam int DW = 64;
    localparam int KW = 4;
    localparam int DRAIN = 3;

    logic clk = 1'b0, rst_ni;
    logic cfg_valid, cfg_ready, cfg_mode;
    logic [3:0] cm11_1, cm21_1, cm11_2, cm21_2;
    logic s_valid, s_ready, s_last;
    logic [DW-1:0] s_a1, s_b1, s_a2, s_b2;
    logic eng_rst, eng_en, eng_mode, eng_done;
    logic [3:0] em11_1, em21_1, em11_2, em21_2;
    logic [DW-1:0] ain1, bin1, ain2, bin2;
    logic [31:0] ec0, ec1, ec2, ec3;
    logic r_valid, r_ready;
    logic [31:0] rc0, rc1, rc2, rc3;

    dmme_feeder #(.DW(DW), .KW(KW), .DRAIN(DRAIN)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_mode_i(cfg_mode),
        .cfg_mask11_1_i(cm11_1), .cfg_mask21_1_i(cm21_1),
        .cfg_mask11_2_i(cm11_2), .cfg_mask21_2_i(cm21_2),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_a1_i(s_a1), .s_b1_i(s_b1), .s_a2_i(s_a2), .s_b2_i(s_b2), .s_last_i(s_last),
        .eng_rst_o(eng_rst), .eng_en_o(eng_en), .eng_mode_o(eng_mode),
        .eng_mask11_1_o(em11_1), .eng_mask21_1_o(em21_1),
        .eng_mask11_2_o(em11_2), .eng_mask21_2_o(em21_2),
        .eng_ain1_o(ain1), .eng_bin1_o(bin1), .eng_ain2_o(ain2), .eng_bin2_o(bin2),
        .eng_done_i(eng_done),
        .eng_c12_1_i(ec0), .eng_c22_1_i(ec1), .eng_c12_2_i(ec2), .eng_c22_2_i(ec3),
        .r_valid_o(r_valid), .r_ready_i(r_ready),
        .r_c12_1_o(rc0), .r_c22_1_o(rc1), .r_c12_2_o(rc2), .r_c22_2_o(rc3)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Job description; cycle 0 is the cfg handshake cycle.
    int k, L, D, H, tail, ddelay, rdelay;
    bit nolast, early, m;
    int acc[32];
    int st[32];
    logic [3:0] msk[4];
    logic [31:0] res[4];
    logic [63:0] ba1[32], bb1[32], ba2[32], bb2[32];

    logic [63:0] o_ain1[256], o_ain2[256];
    logic o_en[256], o_rv[256];
    logic [31:0] o_r[4];

    task automatic chk(input string nm, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    function automatic int latest(int c);
        int j = -1;
        for (int i = 0; i < k; i++) if (acc[i] < c) j = i;
        return j;
    endfunction

    function automatic bit accepted_at(int c);
        for (int i = 0; i < k; i++) if (acc[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_cycle(input int c);
        int j;
        bit on;
        logic [63:0] ea1, eb1, ea2, eb2;
        j  = latest(c);
        on = (c >= 1) && (c <= H);
        if (c > L + 1 || j < 0) begin
            ea1 = '0; eb1 = '0;
        end else begin
            ea1 = ba1[j]; eb1 = bb1[j];
        end
        if (c == L + 2) begin
            ea2 = ba2[k-1]; eb2 = bb2[k-1];
        end else if (c > L + 2 || j < 1) begin
            ea2 = '0; eb2 = '0;
        end else begin
            ea2 = ba2[j-1]; eb2 = bb2[j-1];
        end
        chk("ain1", c, ain1, ea1);
        chk("bin1", c, bin1, eb1);
        chk("ain2", c, ain2, ea2);
        chk("bin2", c, bin2, eb2);
        chk("eng_en", c, eng_en, accepted_at(c - 1) || (c > L + 1 && c <= D));
        chk("eng_rst", c, eng_rst, c != 1);
        chk("cfg_ready", c, cfg_ready, c == 0 || c > H);
        chk("s_ready", c, s_ready, c >= 2 && c <= L);
        chk("eng_mode", c, eng_mode, on ? m : 1'b0);
        chk("masks", c, {em11_1, em21_1, em11_2, em21_2},
            on ? {msk[0], msk[1], msk[2], msk[3]} : 16'h0);
        chk("r_valid", c, r_valid, c > D && c <= H);
        if (c > D && c <= H) chk("r_data", c, {rc0, rc1, rc2, rc3},
                                 {res[0], res[1], res[2], res[3]});
        o_ain1[c] = ain1; o_ain2[c] = ain2; o_en[c] = eng_en; o_rv[c] = r_valid;
        if (c == H) o_r = '{rc0, rc1, rc2, rc3};
    endtask

    task automatic drive(input int c);
        cfg_valid = (c == 0);
        if (c == 0) begin
            cfg_mode = m; {cm11_1, cm21_1, cm11_2, cm21_2} = {msk[0], msk[1], msk[2], msk[3]};
        end else begin
            cfg_mode = 1'($urandom); {cm11_1, cm21_1, cm11_2, cm21_2} = 16'($urandom);
        end
        s_valid = 1'b0;
        s_last  = 1'($urandom);
        s_a1 = {$urandom, $urandom}; s_b1 = {$urandom, $urandom};
        s_a2 = {$urandom, $urandom}; s_b2 = {$urandom, $urandom};
        for (int j = 0; j < k; j++) begin
            if (acc[j] == c) begin
                s_valid = 1'b1;
                s_last  = (j == k - 1) && !nolast;
                s_a1 = ba1[j]; s_b1 = bb1[j]; s_a2 = ba2[j]; s_b2 = bb2[j];
            end
        end
        eng_done = (c == D) || (early && (c == 1 || c == 2 || c == L + 1)) ||
                   (c > H && $urandom_range(0, 3) == 0);
        if (c == D) {ec0, ec1, ec2, ec3} = {res[0], res[1], res[2], res[3]};
        else {ec0, ec1, ec2, ec3} = {$urandom, $urandom, $urandom, $urandom};
        r_ready = (c == H) || ((c <= D || c > H) && $urandom_range(0, 1) == 1);
    endtask

    task automatic setup(input int kk);
        k = kk; nolast = 0; early = 0; m = 0; ddelay = DRAIN + 1; rdelay = 0; tail = 0;
        for (int i = 0; i < 4; i++) begin msk[i] = '0; res[i] = $urandom; end
        for (int j = 0; j < 32; j++) begin
            st[j] = 0;
            ba1[j] = {$urandom, $urandom}; bb1[j] = {$urandom, $urandom};
            ba2[j] = {$urandom, $urandom}; bb2[j] = {$urandom, $urandom};
        end
    endtask

    task automatic run_job();
        int t = 2;
        for (int j = 0; j < k; j++) begin
            t += st[j]; acc[j] = t; t++;
        end
        L = acc[k-1];
        D = L + 2 + ddelay;
        H = D + 1 + rdelay;
        for (int c = 0; c <= H + tail; c++) begin
            drive(c);
            @(negedge clk);
            check_cycle(c);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_outs"}, 0, {cfg_ready, s_ready, eng_rst, eng_en, eng_mode, r_valid}, '0);
        chk({nm, "_masks"}, 0, {em11_1, em21_1, em11_2, em21_2}, '0);
        chk({nm, "_lane1"}, 0, ain1 | bin1, '0);
        chk({nm, "_lane2"}, 0, ain2 | bin2, '0);
        chk({nm, "_res"}, 0, {rc0, rc1, rc2, rc3} == '0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; cfg_valid = 0; cfg_mode = 0; {cm11_1, cm21_1, cm11_2, cm21_2} = '0;
        s_valid = 0; s_last = 0; s_a1 = '0; s_b1 = '0; s_a2 = '0; s_b2 = '0;
        eng_done = 0; {ec0, ec1, ec2, ec3} = '0; r_ready = 0;
        #3 check_zero("reset");
        @(posedge clk); #1 rst_ni = 1'b1;
        #1 chk("cfg_ready_pre_clk", 0, cfg_ready, 0);
        @(posedge clk); #1;
        chk("cfg_ready_first_clk", 0, cfg_ready, 1);
        chk("eng_rst_first_clk", 0, eng_rst, 1);

        // Dense two-beat job.
        setup(2);
        ba1[0] = 64'h2345678923456789; bb1[0] = 64'h1111000011110000;
        ba2[0] = 64'h8765432187654321; bb2[0] = 64'h0000111100001111;
        ba1[1] = 64'h1111000011110000; bb1[1] = 64'h2345678923456789;
        ba2[1] = 64'h0000111100001111; bb2[1] = 64'h8765432187654321;
        run_job();
        chk("pin_ain1_b0", 3, o_ain1[3], 64'h2345678923456789);
        chk("pin_ain2_b0", 3, o_ain2[3], 64'h0);
        chk("pin_ain1_b1", 4, o_ain1[4], 64'h1111000011110000);
        chk("pin_ain2_b1", 4, o_ain2[4], 64'h8765432187654321);
        chk("pin_ain1_end", 5, o_ain1[5], 64'h0);
        chk("pin_ain2_end", 5, o_ain2[5], 64'h0000111100001111);

        // Sparse single-beat job.
        setup(1);
        m = 1; msk = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
        ba2[0] = 64'h8765432187654321;
        run_job();
        chk("pin_sparse_lane2", 4, o_ain2[4], 64'h8765432187654321);

        // Two-cycle stall between beats.
        setup(2);
        st[1] = 2;
        run_job();
        chk("pin_stall_en3", 3, o_en[3], 1);
        chk("pin_stall_en4", 4, o_en[4], 0);
        chk("pin_stall_en5", 5, o_en[5], 0);
        chk("pin_stall_en6", 6, o_en[6], 1);
        chk("pin_stall_hold", 5, o_ain1[5], ba1[0]);
        chk("pin_stall_skew", 6, o_ain2[6], ba2[0]);

        // Result backpressure.
        setup(2);
        res = '{32'h1, 32'h2, 32'h3, 32'h4};
        rdelay = 5;
        run_job();
        chk("pin_res0", H, o_r[0], 32'h1);
        chk("pin_res1", H, o_r[1], 32'h2);
        chk("pin_res2", H, o_r[2], 32'h3);
        chk("pin_res3", H, o_r[3], 32'h4);

        // Reset in the middle of FEED.
        cfg_valid = 1; cfg_mode = 1; {cm11_1, cm21_1, cm11_2, cm21_2} = 16'hffff;
        @(posedge clk); #1 cfg_valid = 0;
        @(posedge clk); #1 s_valid = 1; s_last = 0; s_a1 = 64'hdeadbeef01234567;
        @(posedge clk); #1 s_valid = 0;
        chk("rst_pre_ain1", 3, ain1, 64'hdeadbeef01234567);
        #2 rst_ni = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk); #1 check_zero("midreset_held");
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("rst_cfg_ready", 0, cfg_ready, 1);
        chk("rst_eng_rst", 0, eng_rst, 1);
        chk("rst_lane1", 0, ain1, 64'h0);

        // Done pulses in START, FEED and first DRAIN cycle must be ignored.
        setup(3);
        early = 1;
        run_job();
        chk("pin_early_feed", 3, o_rv[3], 0);
        chk("pin_early_drain", L + 2, o_rv[L+2], 0);

        // No s_last: beat 2^KW is treated as last.
        setup(16);
        nolast = 1;
        run_job();
        chk("pin_sat_lane2", L + 2, o_ain2[L+2], ba2[15]);

        for (int n = 0; n < 30; n++) begin
            setup($urandom_range(1, 16));
            nolast = (k == 16) && ($urandom_range(0, 1) == 1);
            early  = $urandom_range(0, 1) == 1;
            m      = 1'($urandom);
            for (int i = 0; i < 4; i++) msk[i] = 4'($urandom);
            for (int j = 0; j < k; j++) st[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            ddelay = $urandom_range(0, 6);
            rdelay = $urandom_range(0, 4);
            tail   = $urandom_range(0, 2);
            run_job();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmme_feeder.md
# dmme_feeder

Upstream operand sequencer for `dmme_nonmem`. It accepts a job descriptor and a stream of per-k operand beats, then drives the engine's `ain1/bin1` and `ain2/bin2` lanes with the one-cycle systolic skew the engine requires, plus the masks, `mode` and `en`. After feeding, it drains zeros, waits for the engine's `done`, and returns the four 32-bit results on a valid/ready result port.

## Interface
- `DW`, 64, operand lane width (4 × 16-bit elements).
- `KW`, 4, beat-counter width; a job is at most 2^KW beats.
- `DRAIN`, 3, zero-operand cycles driven after lane 2's last beat.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_valid` / `cfg_ready` in / out 1: job descriptor handshake.
- `cfg_mode` in 1: 0 = dense×dense, 1 = sparse×dense.
- `cfg_mask11_1`, `cfg_mask21_1`, `cfg_mask11_2`, `cfg_mask21_2` in 4 each: sparsity masks.
- `s_valid` / `s_ready` in / out 1: operand beat handshake.
- `s_a1`, `s_b1`, `s_a2`, `s_b2` in DW each: lane-1 and lane-2 operands for one k-step.
- `s_last` in 1: marks the final beat of the job.
- `eng_rst` out 1: active-low engine clear.
- `eng_en`, `eng_mode` out 1 each.
- `eng_mask*` out 4 each: four masks to the engine.
- `eng_ain1`, `eng_bin1`, `eng_ain2`, `eng_bin2` out DW each.
- `eng_done` in 1: engine done.
- `eng_c12_1`, `eng_c22_1`, `eng_c12_2`, `eng_c22_2` in 32 each: engine results.
- `r_valid` / `r_ready` out / in 1: result handshake.
- `r_c12_1`, `r_c22_1`, `r_c12_2`, `r_c22_2` out 32 each: registered results.

## Operation
States: IDLE, START, FEED, DRAIN, WAIT, RESULT.
- **IDLE**
  - `cfg_ready` = 1; `s_ready` = 0.
  - On `cfg_valid`: latch mode and masks, go to START.
- **START** (1 cycle)
  - `eng_rst` = 0 clears the engine's accumulators.
  - Masks and mode are driven from START through RESULT.
  - Go to FEED.
- **FEED**
  - `s_ready` = 1.
  - On an accepted beat:
    - lane 1 registers the new `s_a1/s_b1`;
    - lane 2 registers the previous beat's `s_a2/s_b2`, held in a skew register (zero before the first beat);
    - the new `s_a2/s_b2` goes into the skew register;
    - `eng_en` = 1.
  - No beat (`s_valid` = 0): `eng_en` = 0; all lane registers and the skew register hold.
  - Accepted beat with `s_last`: go to DRAIN.
- **DRAIN**
  - First cycle: lane 1 = 0, lane 2 = skew register contents.
  - Then `DRAIN` cycles with all lanes 0.
  - `eng_en` = 1 throughout; go to WAIT.
- **WAIT**
  - `eng_en` = 1, all lanes 0, until `eng_done`.
- **Results**
  - `eng_done` is honoured in the DRAIN cycles after the first, and in WAIT.
  - It is ignored in IDLE, START and FEED.
  - On an honoured `eng_done`: capture the four results into the `r_*` registers, set `r_valid`, go to RESULT.
- **RESULT**
  - `r_*` values are stable while `r_valid` && !`r_ready`.
  - On the handshake: `r_valid` = 0, go to IDLE.
- Beat count over 2^KW without `s_last`: the counter saturates and the beat is treated as last.

## Timing
- Reset values:
  - all outputs 0, except `eng_rst` = 0 asserted;
  - state IDLE; skew register 0.
- First clock after reset release: `eng_rst` = 1 and `cfg_ready` = 1.
- Lane latency:
  - beat k accepted at edge T drives `eng_ain1/bin1` from T until the next accepted beat;
  - its `a2/b2` drives `eng_ain2/bin2` one accepted beat later.
- Minimum job turnaround (K beats, no stalls, `done` d cycles into WAIT): 1 + 1 + K + (1 + DRAIN) + d + 1 cycles.
- `cfg_ready` is 0 from START until RESULT completes; there is no descriptor overlap.
- `rst` asserted mid-job: immediate return to IDLE, all lanes zero, any partial result discarded.
- `eng_done` and `r_ready` cannot collide: `r_ready` is only sampled in RESULT.

## Structure
- Package `dmme_pkg`:
  - state enum;
  - `DW`;
  - the `MODE_DENDEN` = 0 / `MODE_SPADEN` = 1 constants, shared with `dmme_nonmem`.
- One sub-module, `dmme_skew_reg`: the 2×DW lane-2 delay with hold-on-stall and synchronous clear. All else is inline.

## Test plan
- **Dense job, 2 beats.**
  - Stimulus:
    - beat0 a1 = 0x2345678923456789, b1 = 0x1111000011110000, a2 = 0x8765432187654321, b2 = 0x0000111100001111;
    - beat1 a1 = 0x1111000011110000, b1 = 0x2345678923456789, a2 = 0x0000111100001111, b2 = 0x8765432187654321.
  - Required: `eng_ain1` = beat0 then beat1 then 0; `eng_ain2` lags `eng_ain1` by exactly one cycle; `eng_mode` = 0.
- **Sparse job.**
  - Stimulus: mode = 1, all masks 4'b0101, single beat with `s_last`.
  - Required: `eng_mode` = 1 and masks = 0101 from START to RESULT; lane 2 carries the beat in the first DRAIN cycle.
- **Stall.**
  - Stimulus: `s_valid` low for 2 cycles between beat0 and beat1.
  - Required: `eng_en` = 0 for those cycles; `eng_ain1/ain2` hold; skew relation preserved afterwards.
- **Result backpressure.**
  - Stimulus: engine `done` with results 0x1, 0x2, 0x3, 0x4; `r_ready` low for 5 cycles.
  - Required: `r_valid` = 1 with values stable; `cfg_ready` = 0 until the handshake.
- **Reset mid-FEED.**
  - Stimulus: `rst` = 0 after beat0.
  - Required: all outputs 0 and `eng_rst` = 0 immediately; `cfg_ready` = 1 on the first clock after release.
- **Early done.**
  - Stimulus: `eng_done` pulsed in FEED.
  - Required: the pulse is ignored; the job completes only on a later `done` in WAIT.
